// File: rtl/datapath_if.sv
// Signal bundle between the datapath and its controller/memories.
// Carries control word, memory ports, I/O, status flags and register debug taps.
interface datapath_if;
   logic [1:14] controlBits;
   logic [7:0]  romData;
   logic [7:0]  ramRdata;
   logic [7:0]  inPort;
   logic [7:0]  ir;
   logic        aIsZero;
   logic        flagCarry;
   logic [7:0]  romAddr;
   logic [7:0]  ramAddr;
   logic [7:0]  ramWdata;
   logic        ramWe;
   logic [7:0]  qOut;
   logic        busConflict;
   logic [7:0]  dbg_a;
   logic [7:0]  dbg_b;
   logic [7:0]  dbg_x;
   logic [7:0]  dbg_bus;

   modport master (
      output controlBits, romData, ramRdata, inPort,
      input  ir, aIsZero, flagCarry, romAddr, ramAddr, ramWdata, ramWe,
             qOut, busConflict, dbg_a, dbg_b, dbg_x, dbg_bus
   );

   modport slave (
      input  controlBits, romData, ramRdata, inPort,
      output ir, aIsZero, flagCarry, romAddr, ramAddr, ramWdata, ramWe,
             qOut, busConflict, dbg_a, dbg_b, dbg_x, dbg_bus
   );
endinterface

// File: rtl/datapath.sv
// 8-bit accumulator datapath: shared priority bus, 9-bit add/sub ALU,
// registers IR/PC/A/B/X/Q and a carry flag. Registers load from the bus.
module datapath (
   input  logic     clk,
   input  logic     resetBar,
   datapath_if.slave dp
);
   logic load_ir_n, store_mem_n;
   logic trig_a_n, trig_b_n, trig_x_n, trig_q_n;
   logic rom_n, ram_n, a_n, x_n, e_n, s_n;
   logic do_sub, do_jump;

   assign {load_ir_n, store_mem_n, trig_a_n, trig_b_n, trig_x_n, trig_q_n,
           rom_n, ram_n, a_n, x_n, e_n, s_n, do_sub, do_jump} = dp.controlBits;

   logic [7:0] ir_q, ir_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] x_q, x_d;
   logic [7:0] q_q, q_d;
   logic       carry_q, carry_d;

   logic [7:0] bus;
   logic [7:0] b_op;
   logic [8:0] alu_sum;
   logic [5:0] src_low;

   // Subtraction is A + ~B + 1, so carry out set means no borrow.
   always_comb begin
      b_op    = do_sub ? ~b_q : b_q;
      alu_sum = {1'b0, a_q} + {1'b0, b_op} + {8'h00, do_sub};
   end

   always_comb begin
      bus = 8'h00;
      if (!rom_n)      bus = dp.romData;
      else if (!ram_n) bus = dp.ramRdata;
      else if (!a_n)   bus = a_q;
      else if (!x_n)   bus = x_q;
      else if (!e_n)   bus = alu_sum[7:0];
      else if (!s_n)   bus = dp.inPort;
   end

   // More than one bit set in src_low means a bus fight.
   assign src_low = ~{rom_n, ram_n, a_n, x_n, e_n, s_n};

   always_comb begin
      ir_d    = load_ir_n ? ir_q : bus;
      pc_d    = do_jump ? bus : pc_q + 8'd1;
      a_d     = trig_a_n ? a_q : bus;
      b_d     = trig_b_n ? b_q : bus;
      x_d     = trig_x_n ? x_q : bus;
      q_d     = trig_q_n ? q_q : bus;
      carry_d = (!trig_a_n && !e_n) ? alu_sum[8] : carry_q;
   end

   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         ir_q    <= 8'h00;
         pc_q    <= 8'h00;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         x_q     <= 8'h00;
         q_q     <= 8'h00;
         carry_q <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         x_q     <= x_d;
         q_q     <= q_d;
         carry_q <= carry_d;
      end
   end

   assign dp.ir          = ir_q;
   assign dp.aIsZero     = (a_q == 8'h00);
   assign dp.flagCarry   = carry_q;
   assign dp.romAddr     = pc_q;
   assign dp.ramAddr     = x_q;
   assign dp.ramWdata    = bus;
   assign dp.ramWe       = ~store_mem_n;
   assign dp.qOut        = q_q;
   assign dp.busConflict = ((src_low & (src_low - 6'd1)) != 6'd0);
   assign dp.dbg_a       = a_q;
   assign dp.dbg_b       = b_q;
   assign dp.dbg_x       = x_q;
   assign dp.dbg_bus     = bus;
endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: table of single-step vectors plus hand sequences for
// fetch, jump, PC wrap and asynchronous reset; expected values go through a queue.
module tb_datapath;
   localparam int SRC_NONE = 0, SRC_ROM = 1, SRC_RAM = 2, SRC_A = 3,
                  SRC_X = 4, SRC_E = 5, SRC_S = 6;
   localparam logic [5:0] L_NONE = 6'b000000, L_IR = 6'b100000,
                          L_MEM = 6'b010000, L_A = 6'b001000,
                          L_B = 6'b000100, L_X = 6'b000010, L_Q = 6'b000001;
   localparam int O_A = 0, O_B = 1, O_X = 2, O_Q = 3, O_IR = 4, O_PC = 5,
                  O_C = 6, O_Z = 7, O_WD = 8, O_WE = 9, O_RA = 10, O_CF = 11;

   typedef struct {
      string       name;
      logic [1:14] ctrl;
      logic [7:0]  rom;
      logic [7:0]  ram;
      logic [7:0]  inp;
      logic        clk_it;
      int          sel;
      logic [7:0]  exp;
   } vec_t;

   logic clk;
   logic resetBar;
   datapath_if dp_if ();

   datapath dut (
      .clk      (clk),
      .resetBar (resetBar),
      .dp       (dp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   int n_pass = 0;
   int n_total = 0;
   vec_t vecs[32];

   function automatic logic [1:14] mk(input int src1, input int src2,
                                      input logic [5:0] en, input logic sub,
                                      input logic jmp);
      logic [5:0] asrt;
      asrt = 6'b111111;
      if (src1 >= 1 && src1 <= 6) asrt[6 - src1] = 1'b0;
      if (src2 >= 1 && src2 <= 6) asrt[6 - src2] = 1'b0;
      return {~en, asrt, sub, jmp};
   endfunction

   function automatic logic [7:0] observe(input int sel);
      case (sel)
         O_A:  return dp_if.dbg_a;
         O_B:  return dp_if.dbg_b;
         O_X:  return dp_if.dbg_x;
         O_Q:  return dp_if.qOut;
         O_IR: return dp_if.ir;
         O_PC: return dp_if.romAddr;
         O_C:  return {7'b0, dp_if.flagCarry};
         O_Z:  return {7'b0, dp_if.aIsZero};
         O_WD: return dp_if.ramWdata;
         O_WE: return {7'b0, dp_if.ramWe};
         O_RA: return dp_if.ramAddr;
         default: return {7'b0, dp_if.busConflict};
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] act);
      logic [7:0] e;
      n_total++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: got %02h but no expected value queued", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act === e) n_pass++;
         else $display("FAIL %s: got %02h want %02h", name, act, e);
      end
   endtask

   task automatic drive(input logic [1:14] ctrl, input logic [7:0] rom,
                        input logic [7:0] ram, input logic [7:0] inp);
      dp_if.controlBits = ctrl;
      dp_if.romData     = rom;
      dp_if.ramRdata    = ram;
      dp_if.inPort      = inp;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input vec_t v);
      drive(v.ctrl, v.rom, v.ram, v.inp);
      exp_q.push_back(v.exp);
      if (v.clk_it) tick();
      else #1;
      check(v.name, observe(v.sel));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"ld_a_f0",   mk(SRC_ROM, 0, L_A, 0, 0),  8'hF0, 8'h00, 8'h00, 1'b1, O_A,  8'hF0};
      vecs[1]  = '{"ld_b_20",   mk(SRC_ROM, 0, L_B, 0, 0),  8'h20, 8'h00, 8'h00, 1'b1, O_B,  8'h20};
      vecs[2]  = '{"add_a",     mk(SRC_E, 0, L_A, 0, 0),    8'h00, 8'h00, 8'h00, 1'b1, O_A,  8'h10};
      vecs[3]  = '{"add_carry", mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_C, 8'h01};
      vecs[4]  = '{"ld_a_00",   mk(SRC_ROM, 0, L_A, 0, 0),  8'h00, 8'h00, 8'h00, 1'b1, O_A,  8'h00};
      vecs[5]  = '{"zero_a",    mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_Z, 8'h01};
      vecs[6]  = '{"carry_hold", mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_C, 8'h01};
      vecs[7]  = '{"ld_a_05",   mk(SRC_ROM, 0, L_A, 0, 0),  8'h05, 8'h00, 8'h00, 1'b1, O_A,  8'h05};
      vecs[8]  = '{"ld_b_07",   mk(SRC_ROM, 0, L_B, 0, 0),  8'h07, 8'h00, 8'h00, 1'b1, O_B,  8'h07};
      vecs[9]  = '{"sub_a",     mk(SRC_E, 0, L_A, 1, 0),    8'h00, 8'h00, 8'h00, 1'b1, O_A,  8'hFE};
      vecs[10] = '{"borrow",    mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_C, 8'h00};
      vecs[11] = '{"ld_a_07",   mk(SRC_ROM, 0, L_A, 0, 0),  8'h07, 8'h00, 8'h00, 1'b1, O_A,  8'h07};
      vecs[12] = '{"sub_eq",    mk(SRC_E, 0, L_A, 1, 0),    8'h00, 8'h00, 8'h00, 1'b1, O_A,  8'h00};
      vecs[13] = '{"sub_eq_c",  mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_C, 8'h01};
      vecs[14] = '{"sub_eq_z",  mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_Z, 8'h01};
      vecs[15] = '{"ld_x_s",    mk(SRC_S, 0, L_X, 0, 0),    8'h00, 8'h00, 8'h10, 1'b1, O_X,  8'h10};
      vecs[16] = '{"ld_a_33",   mk(SRC_ROM, 0, L_A, 0, 0),  8'h33, 8'h00, 8'h00, 1'b1, O_A,  8'h33};
      vecs[17] = '{"st_wdata",  mk(SRC_A, 0, L_MEM, 0, 0),  8'h00, 8'h00, 8'h00, 1'b0, O_WD, 8'h33};
      vecs[18] = '{"st_we",     mk(SRC_A, 0, L_MEM, 0, 0),  8'h00, 8'h00, 8'h00, 1'b0, O_WE, 8'h01};
      vecs[19] = '{"st_addr",   mk(SRC_A, 0, L_MEM, 0, 0),  8'h00, 8'h00, 8'h00, 1'b0, O_RA, 8'h10};
      vecs[20] = '{"conf_ax",   mk(SRC_A, SRC_X, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_CF, 8'h01};
      vecs[21] = '{"conf_bus",  mk(SRC_A, SRC_X, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_WD, 8'h33};
      vecs[22] = '{"idle_bus",  mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h55, 8'h66, 8'h77, 1'b0, O_WD, 8'h00};
      vecs[23] = '{"idle_conf", mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_CF, 8'h00};
      vecs[24] = '{"ld_q_ram",  mk(SRC_RAM, 0, L_Q, 0, 0),  8'h00, 8'h99, 8'h00, 1'b1, O_Q,  8'h99};
      vecs[25] = '{"dual_a",    mk(SRC_E, 0, L_A | L_B, 0, 0), 8'h00, 8'h00, 8'h00, 1'b1, O_A, 8'h3A};
      vecs[26] = '{"dual_b",    mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_B, 8'h3A};
      vecs[27] = '{"dual_c",    mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_C, 8'h00};
      vecs[28] = '{"prio_rom_s", mk(SRC_ROM, SRC_S, L_NONE, 0, 0), 8'h11, 8'h00, 8'h22, 1'b0, O_WD, 8'h11};
      vecs[29] = '{"ld_q_x",    mk(SRC_X, 0, L_Q, 0, 0),    8'h00, 8'h00, 8'h00, 1'b1, O_Q,  8'h10};
      vecs[30] = '{"e_to_q",    mk(SRC_E, 0, L_Q, 1, 0),    8'h00, 8'h00, 8'h00, 1'b1, O_Q,  8'h00};
      vecs[31] = '{"e_q_c_hold", mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00, 1'b0, O_C, 8'h00};

      // Power-up reset
      resetBar = 1'b0;
      drive(mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00);
      #3;
      for (int s = O_A; s <= O_PC; s++) begin
         exp_q.push_back(8'h00);
         check($sformatf("rst_reg%0d", s), observe(s));
      end
      exp_q.push_back(8'h00); check("rst_carry", observe(O_C));
      exp_q.push_back(8'h01); check("rst_zero", observe(O_Z));
      #9;
      resetBar = 1'b1;

      // Fetch: three ROM->IR steps
      drive(mk(SRC_ROM, 0, L_IR, 0, 0), 8'h5A, 8'h00, 8'h00);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h03);
      repeat (3) tick();
      check("fetch_ir", observe(O_IR));
      check("fetch_pc", observe(O_PC));

      for (int i = 0; i < 32; i++) apply_vec(vecs[i]);

      // Jump then increment
      drive(mk(SRC_ROM, 0, L_NONE, 0, 1), 8'h42, 8'h00, 8'h00);
      exp_q.push_back(8'h42);
      tick();
      check("jump_42", observe(O_PC));
      drive(mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00);
      exp_q.push_back(8'h43);
      tick();
      check("jump_inc", observe(O_PC));

      // PC wrap from 0xFF
      drive(mk(SRC_ROM, 0, L_NONE, 0, 1), 8'hFF, 8'h00, 8'h00);
      exp_q.push_back(8'hFF);
      tick();
      check("pc_ff", observe(O_PC));
      drive(mk(SRC_NONE, 0, L_NONE, 0, 0), 8'h00, 8'h00, 8'h00);
      exp_q.push_back(8'h00);
      tick();
      check("pc_wrap", observe(O_PC));

      // Make every register non-zero and carry set, then reset mid-cycle
      drive(mk(SRC_E, 0, L_A, 1, 0), 8'h00, 8'h00, 8'h00);
      tick();
      drive(mk(SRC_ROM, 0, L_A | L_Q, 0, 0), 8'hAA, 8'h00, 8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'hAA);
      tick();
      check("pre_rst_carry", observe(O_C));
      check("pre_rst_q", observe(O_Q));
      drive(mk(SRC_NONE, 0, L_A | L_MEM, 0, 0), 8'h77, 8'h00, 8'h00);
      #3;
      resetBar = 1'b0;
      #1;
      for (int s = O_A; s <= O_PC; s++) begin
         exp_q.push_back(8'h00);
         check($sformatf("mid_rst_reg%0d", s), observe(s));
      end
      exp_q.push_back(8'h00); check("mid_rst_carry", observe(O_C));
      exp_q.push_back(8'h01); check("mid_rst_zero", observe(O_Z));
      exp_q.push_back(8'h00); check("mid_rst_raddr", observe(O_RA));
      exp_q.push_back(8'h01); check("mid_rst_we", observe(O_WE));
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      tick();
      check("rst_hold_pc", observe(O_PC));
      check("rst_hold_a", observe(O_A));

      // First edge after release executes the presented control word
      resetBar = 1'b1;
      drive(mk(SRC_ROM, 0, L_IR, 0, 0), 8'hC3, 8'h00, 8'h00);
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'h01);
      tick();
      check("post_rst_ir", observe(O_IR));
      check("post_rst_pc", observe(O_PC));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
